// File: rtl/int_cordic_atanh_logit_rtl_if.sv
// Operand/result bus of the inverse-activation CORDIC unit.
// Handshake: a transfer happens on the rising sys_clk edge where valid and
// ready are both high; the valid side holds its data stable until that edge,
// and ready never depends combinationally on valid.
interface int_cordic_atanh_logit_rtl_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] src_x;
   logic [1:0]            algorithm;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] rho;
   logic                  ovf;

   modport master (
      output in_valid, src_x, algorithm, out_ready,
      input  in_ready, out_valid, rho, ovf
   );

   modport slave (
      input  in_valid, src_x, algorithm, out_ready,
      output in_ready, out_valid, rho, ovf
   );
endinterface

// File: rtl/int_cordic_atanh_logit_rtl.sv
// Inverse activation unit: atanh(t) or logit(p) = 2*atanh(2p-1) computed with
// an iterative hyperbolic CORDIC in vectoring mode (x0 = 1, y0 = t, z -> atanh).
// One operand in flight; fixed latency of ITERATION+2 cycles from acceptance.
module int_cordic_atanh_logit_rtl #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FRAC_WIDTH = 16,
   parameter int                    ITERATION  = 16,
   parameter logic [DATA_WIDTH-1:0] DATA_UNIT  = DATA_WIDTH'(1) << FRAC_WIDTH,
   parameter logic [DATA_WIDTH-1:0] T_LIM      = DATA_WIDTH'(52429),
   parameter logic [DATA_WIDTH-1:0] SAT        = DATA_WIDTH'(32'h0008_0000)
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   int_cordic_atanh_logit_rtl_if.slave  bus,
   output logic [1:0]                   state_dbg
);

   localparam int GW = DATA_WIDTH + 2;
   localparam int CW = $clog2(ITERATION) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREP = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] ALG_ATANH = 2'b10;
   localparam logic [1:0] ALG_LOGIT = 2'b01;

   localparam logic [DATA_WIDTH-1:0] NEG_SAT = DATA_WIDTH'(0) - SAT;

   // Shift schedule 1,2,3,4,4,5,...,13,13,14,...: shifts 4 and 13 are repeated
   // so the hyperbolic iteration converges.
   function automatic logic [5:0] shift_of(input logic [CW-1:0] k);
      logic [5:0] kk;
      kk = 6'(k);
      if (kk < 6'd4)       return kk + 6'd1;
      else if (kk < 6'd14) return kk;
      else                 return kk - 6'd1;
   endfunction

   // atanh(2^-s) in Q16; beyond s = 7 the series is 2^-s to within an LSB.
   function automatic logic signed [GW-1:0] atanh_of(input logic [5:0] s);
      logic signed [GW-1:0] a;
      case (s)
         6'd1:    a = GW'(35999);
         6'd2:    a = GW'(16739);
         6'd3:    a = GW'(8235);
         6'd4:    a = GW'(4101);
         6'd5:    a = GW'(2049);
         6'd6:    a = GW'(1024);
         6'd7:    a = GW'(512);
         default: a = (s <= 6'd16) ? (GW'(1) << (6'd16 - s)) : '0;
      endcase
      return a;
   endfunction

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] src_q, src_d;
   logic [1:0]            alg_q, alg_d;
   logic signed [GW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
   logic [CW-1:0]         iter_q, iter_d;
   logic                  oor_q, oor_d;
   logic                  neg_q, neg_d;
   logic                  zero_q, zero_d;
   logic [DATA_WIDTH-1:0] rho_q, rho_d;
   logic                  ovf_q, ovf_d;

   logic signed [GW-1:0]  y0;
   logic [GW-1:0]         y0_mag;
   logic [5:0]            sh;
   logic signed [GW-1:0]  x_n, y_n, z_n;

   // Initial y from the registered operand, plus one CORDIC micro-step on the current x/y/z.
   always_comb begin
      logic signed [GW-1:0] sx;
      logic signed [GW-1:0] xs;
      logic signed [GW-1:0] ys;
      logic signed [GW-1:0] a;
      sx = $signed({{2{src_q[DATA_WIDTH-1]}}, src_q});
      case (alg_q)
         ALG_ATANH: y0 = sx;
         ALG_LOGIT: y0 = (sx <<< 1) - $signed(GW'(DATA_UNIT));
         default:   y0 = '0;
      endcase
      y0_mag = y0[GW-1] ? GW'(-y0) : GW'(y0);
      sh = shift_of(iter_q);
      xs = x_q >>> sh;
      ys = y_q >>> sh;
      a  = atanh_of(sh);
      if (y_q[GW-1]) begin
         x_n = x_q + ys;
         y_n = y_q + xs;
         z_n = z_q - a;
      end else begin
         x_n = x_q - ys;
         y_n = y_q - xs;
         z_n = z_q + a;
      end
   end

   // Next-state logic: IDLE -> PREP -> ITER (ITERATION cycles) -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      alg_d   = alg_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      iter_d  = iter_q;
      oor_d   = oor_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      rho_d   = rho_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               src_d   = bus.src_x;
               alg_d   = bus.algorithm;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            x_d     = $signed(GW'(DATA_UNIT));
            y_d     = y0;
            z_d     = '0;
            oor_d   = (y0_mag >= GW'(T_LIM));
            neg_d   = y0[GW-1];
            // sign(0) steering would wander around zero; an exact zero maps to an exact zero
            zero_d  = (y0 == '0);
            iter_d  = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            x_d    = x_n;
            y_d    = y_n;
            z_d    = z_n;
            iter_d = iter_q + CW'(1);
            if (iter_q == CW'(ITERATION - 1)) begin
               state_d = S_DONE;
               if (alg_q != ALG_ATANH && alg_q != ALG_LOGIT) begin
                  rho_d = '0;
                  ovf_d = 1'b0;
               end else if (oor_q) begin
                  rho_d = neg_q ? NEG_SAT : SAT;
                  ovf_d = 1'b1;
               end else if (zero_q) begin
                  rho_d = '0;
                  ovf_d = 1'b0;
               end else if (alg_q == ALG_LOGIT) begin
                  rho_d = {z_n[DATA_WIDTH-2:0], 1'b0};
                  ovf_d = 1'b0;
               end else begin
                  rho_d = z_n[DATA_WIDTH-1:0];
                  ovf_d = 1'b0;
               end
            end
         end
         default: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operand.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         alg_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         iter_q  <= '0;
         oor_q   <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
         rho_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         alg_q   <= alg_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         iter_q  <= iter_d;
         oor_q   <= oor_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
         rho_q   <= rho_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.rho       = rho_q;
   assign bus.ovf       = ovf_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_int_cordic_atanh_logit_rtl.sv
// Directed bench for the atanh/logit CORDIC unit: driver tasks push expected
// results into a queue, a negedge monitor pops and compares on each output.
module tb_int_cordic_atanh_logit_rtl;

   localparam logic [1:0] ATANH = 2'b10;
   localparam logic [1:0] LOGIT = 2'b01;
   localparam int         LAT   = 17;   // first negedge with out_valid, in edges after acceptance

   logic        sys_clk;
   logic        sys_rst_n;
   logic [1:0]  state_dbg;

   int_cordic_atanh_logit_rtl_if #(.DATA_WIDTH(32)) bus_if ();

   int_cordic_atanh_logit_rtl dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_if),
      .state_dbg (state_dbg)
   );

   // clock / cycle counter
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // scoreboard state: expected entry = {ovf, tol[7:0], rho[31:0]}
   logic [40:0] exp_q[$];
   int          acc_q[$];
   int          passed = 0;
   int          total  = 0;

   function automatic logic [40:0] pk(input logic [31:0] r, input int tol, input logic o);
      return {o, 8'(tol), r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int tol);
      int diff;
      diff = $signed(act) - $signed(req);
      if (diff < 0) diff = -diff;
      total++;
      if (diff <= tol) passed++;
      else $display("FAIL %s: got %h, need %h (tol %0d) at cycle %0d", name, act, req, tol, cyc);
   endtask

   task automatic fail_now(input string name);
      total++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // driver: present an operand, hold until accepted, record acceptance edge
   task automatic send(input logic [31:0] x, input logic [1:0] a, input logic [40:0] e, output int acc);
      int n;
      @(negedge sys_clk);
      bus_if.in_valid  = 1'b1;
      bus_if.src_x     = x;
      bus_if.algorithm = a;
      n = 0;
      while (!bus_if.in_ready && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      acc = -1;
      if (!bus_if.in_ready) begin
         fail_now("accept_timeout");
      end else begin
         acc = cyc + 1;
         exp_q.push_back(e);
         acc_q.push_back(acc);
      end
      @(posedge sys_clk);
      #1;
      bus_if.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
      @(posedge sys_clk);
      #1;
   endtask

   // monitor: latency on first out_valid, hold stability, compare on handshake
   logic        seen = 1'b0;
   logic [31:0] held_rho;
   logic        held_ovf;
   logic [40:0] e_m;
   int          a_m;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         seen = 1'b0;
      end else if (bus_if.out_valid) begin
         if (!seen) begin
            seen     = 1'b1;
            held_rho = bus_if.rho;
            held_ovf = bus_if.ovf;
            if (acc_q.size() != 0) begin
               a_m = acc_q.pop_front();
               check("latency", 32'(cyc - a_m), 32'(LAT), 0);
            end
         end else begin
            check("hold_rho", bus_if.rho, held_rho, 0);
            check("hold_ovf", {31'b0, bus_if.ovf}, {31'b0, held_ovf}, 0);
         end
         if (bus_if.out_ready) begin
            seen = 1'b0;
            if (exp_q.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               e_m = exp_q.pop_front();
               check("rho", bus_if.rho, e_m[31:0], int'(e_m[39:32]));
               check("ovf", {31'b0, bus_if.ovf}, {31'b0, e_m[40]}, 0);
            end
         end
      end
   end

   // stimulus
   initial begin
      int acc1, acc2, n;
      sys_rst_n          = 1'b0;
      bus_if.in_valid    = 1'b0;
      bus_if.src_x       = '0;
      bus_if.algorithm   = 2'b00;
      bus_if.out_ready   = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_in_ready",  {31'b0, bus_if.in_ready},  32'd1, 0);
      check("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0, 0);
      check("rst_rho",       bus_if.rho,                32'd0, 0);
      check("rst_ovf",       {31'b0, bus_if.ovf},       32'd0, 0);
      check("rst_state",     {30'b0, state_dbg},        32'd0, 0);
      sys_rst_n = 1'b1;

      // main function
      send(32'h0000_8000, ATANH, pk(32'h0000_8C9F, 16, 1'b0), acc1);
      send(32'hFFFF_8000, ATANH, pk(32'hFFFF_7361, 16, 1'b0), acc1);
      send(32'h0000_8000, LOGIT, pk(32'h0000_0000, 16, 1'b0), acc1);
      send(32'h0000_C000, LOGIT, pk(32'h0001_193F, 16, 1'b0), acc1);
      send(32'h0000_4000, LOGIT, pk(32'hFFFE_E6C1, 16, 1'b0), acc1);
      send(32'h0000_0000, ATANH, pk(32'h0000_0000, 0,  1'b0), acc1);
      // saturation and range boundary
      send(32'h0000_E666, ATANH, pk(32'h0008_0000, 0,  1'b1), acc1);
      send(32'h0000_0CCD, LOGIT, pk(32'hFFF8_0000, 0,  1'b1), acc1);
      send(32'h0000_CCCD, ATANH, pk(32'h0008_0000, 0,  1'b1), acc1);
      send(32'hFFFF_3333, ATANH, pk(32'hFFF8_0000, 0,  1'b1), acc1);
      send(32'h0000_CCCC, ATANH, pk(32'h0001_193C, 16, 1'b0), acc1);
      send(32'h0001_0000, LOGIT, pk(32'h0008_0000, 0,  1'b1), acc1);
      send(32'h0000_0000, LOGIT, pk(32'hFFF8_0000, 0,  1'b1), acc1);
      // null ops
      send(32'h0000_8000, 2'b11, pk(32'h0000_0000, 0,  1'b0), acc1);
      send(32'h0000_E666, 2'b00, pk(32'h0000_0000, 0,  1'b0), acc1);
      wait_drain();

      // backpressure in DONE with ignored in_valid pulses
      bus_if.out_ready = 1'b0;
      send(32'h0000_C000, LOGIT, pk(32'h0001_193F, 16, 1'b0), acc1);
      n = 0;
      while (!bus_if.out_valid && n < 40) begin
         @(negedge sys_clk);
         n++;
      end
      if (!bus_if.out_valid) fail_now("bp_valid_timeout");
      for (int i = 0; i < 10; i++) begin
         @(posedge sys_clk);
         #1;
         bus_if.in_valid  = 1'b1;
         bus_if.src_x     = 32'h0000_4000 + 32'(i);
         bus_if.algorithm = ATANH;
         @(negedge sys_clk);
         check("bp_in_ready", {31'b0, bus_if.in_ready},  32'd0, 0);
         check("bp_valid",    {31'b0, bus_if.out_valid}, 32'd1, 0);
      end
      @(posedge sys_clk);
      #1;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("bp_ready_after", {31'b0, bus_if.in_ready},  32'd1, 0);
      check("bp_valid_after", {31'b0, bus_if.out_valid}, 32'd0, 0);

      // back-to-back issue interval
      send(32'h0000_8000, ATANH, pk(32'h0000_8C9F, 16, 1'b0), acc1);
      send(32'hFFFF_8000, ATANH, pk(32'hFFFF_7361, 16, 1'b0), acc2);
      check("issue_interval", 32'(acc2 - acc1), 32'd19, 0);
      wait_drain();

      // reset mid-iteration
      send(32'h0000_C000, LOGIT, pk(32'h0001_193F, 16, 1'b0), acc1);
      repeat (8) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      check("midrst_out_valid", {31'b0, bus_if.out_valid}, 32'd0, 0);
      check("midrst_rho",       bus_if.rho,                32'd0, 0);
      check("midrst_ovf",       {31'b0, bus_if.ovf},       32'd0, 0);
      check("midrst_in_ready",  {31'b0, bus_if.in_ready},  32'd1, 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check("postrst_in_ready", {31'b0, bus_if.in_ready},  32'd1, 0);
      send(32'h0000_8000, ATANH, pk(32'h0000_8C9F, 16, 1'b0), acc1);
      wait_drain();

      repeat (3) @(negedge sys_clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/int_cordic_atanh_logit_rtl.md
# int_cordic_atanh_logit_rtl

Inverse activation unit: computes atanh(t) or logit(p) = ln(p/(1-p)) on a signed fixed-point operand using an iterative hyperbolic CORDIC in vectoring mode. It uses no divider and no exp block. It is the inverse counterpart of the tanh/sigmoid activation unit, and maps post-activation values back to pre-activation space for calibration and debug readback. A valid/ready handshake sits on both sides. The unit processes one operand at a time.

## Interface
- DATA_WIDTH, 32: operand/result width, two's complement
- FRAC_WIDTH, 16: fractional bits (Q15.16 at defaults)
- ITERATION, 16: CORDIC micro-steps; shift schedule 1,2,3,4,4,5,…,13,13,14,… (shifts 4 and 13 repeated), truncated to ITERATION entries
- DATA_UNIT, 1.0 in Q format (0x00010000 at defaults)
- T_LIM, 52429: |y0| limit (0.8 in Q16); at or above the limit the result saturates
- SAT, 0x00080000: saturation magnitude (8.0)
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  unit idle and able to accept; reset value 1
- src_x  in  DATA_WIDTH  operand: t for atanh, p for logit
- algorithm  in  2  2'b10 = atanh, 2'b01 = logit, other codes = null op; sampled with src_x
- out_valid  out  1  result valid; reset value 0
- out_ready  in  1  downstream accepts the result
- rho  out  DATA_WIDTH  result; reset value 0; held stable while out_valid=1
- ovf  out  1  input out of range, rho is saturated; reset value 0

## Operation
- FSM states and transitions:
  - IDLE → PREP on in_valid & in_ready; src_x and algorithm are registered on that edge
  - PREP → ITER after one cycle
  - ITER → DONE after ITERATION cycles
  - DONE → IDLE on out_ready
- in_ready = (state == IDLE). out_valid = (state == DONE).
- PREP step:
  - x = DATA_UNIT, z = 0
  - y = t for atanh; y = 2p - DATA_UNIT for logit; y = 0 for a null op
  - out-of-range flag = (|y| >= T_LIM), latched
- Internal x, y, z carry 2 guard bits (DATA_WIDTH+2); all shifts are arithmetic.
- ITER step k, with shift s = schedule[k] and σ = +1 if y<0, else -1:
  - x ← x + σ·(y>>>s)
  - y ← y + σ·(x>>>s) (uses the old x)
  - z ← z - σ·A(s)
- A(s) = atanh(2^-s) in Q16 from an internal constant table: 35999, 16739, 8235, 4101, 2049, 1024, 512; for s ≥ 8, A(s) = 2^(16-s).
- Result on entering DONE:
  - atanh: rho = z
  - logit: rho = 2z (left shift 1)
  - null op: rho = 0, ovf = 0
  - out of range: rho = +SAT if y0 > 0 else -SAT, ovf = 1; iteration still runs, so latency stays constant
- Result is truncated from the guard width to DATA_WIDTH.
- Accuracy: |rho - ideal| ≤ 16 LSB for in-range inputs at default parameters.

## Timing
- Acceptance edge E: PREP is the cycle after E; ITER occupies ITERATION cycles; out_valid rises after edge E+ITERATION+1, giving a fixed latency of ITERATION+2 cycles.
- DONE holds rho, ovf and out_valid indefinitely until out_ready=1. Handshake completes on the edge where out_valid & out_ready.
- in_ready rises in the cycle after the output handshake; minimum issue interval is ITERATION+3 cycles.
- in_valid while busy is ignored. The upstream holds the operand until in_ready.
- out_ready asserted before DONE has no effect.
- Async reset at any point, including mid-ITER or in DONE:
  - state = IDLE, out_valid = 0, rho = 0, ovf = 0 immediately
  - the in-flight operand is discarded
  - the first acceptance after reset release follows normal timing
- Boundary inputs:
  - |y0| = T_LIM exactly counts as out of range
  - logit p = 0 or p = 1 saturates (y0 = ∓1.0)
  - atanh t = 0 returns exactly 0

## Test plan
- atanh, src_x = 0x00008000 (0.5): out_valid exactly 18 cycles after acceptance, rho = 0x00008C9F ±16 LSB, ovf = 0.
- atanh, src_x = 0xFFFF8000 (-0.5): rho = 0xFFFF7361 ±16 LSB. logit, src_x = 0x00008000 (0.5): rho within ±16 of 0.
- logit, src_x = 0x0000C000 (0.75): rho = 0x0001193F (ln 3) ±16 LSB.
- Saturation cases:
  - atanh, src_x = 0x0000E666 (0.9): ovf = 1, rho = 0x00080000
  - logit, src_x = 0x00000CCD (0.05): ovf = 1, rho = 0xFFF80000
  - null-op code 2'b11: rho = 0, ovf = 0
- Backpressure:
  - hold out_ready = 0 for 10 cycles in DONE: rho and out_valid remain stable, and in_valid pulses are ignored
  - release out_ready: in_ready = 1 the next cycle, and back-to-back operands are accepted every 19 cycles
- Reset mid-ITER (cycle 8 of the iterations): out_valid = 0, rho = 0, in_ready = 1 after release; a fresh 0.5 atanh then returns 0x00008C9F with nominal latency.
